// File: rtl/y86_fetch_unit.sv
// Y86-64 pipelined fetch stage: byte-wide instruction memory, decode, next-PC prediction, F->D register.
// FETCH_PREDICT_EN selects jXX/call -> valC prediction; without it every instruction predicts valP.
module y86_fetch_unit #(
   parameter int unsigned            MEM_BYTES = 1024,
   parameter int unsigned            ADDR_W    = 64,
   parameter logic [ADDR_W-1:0]      RESET_PC  = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              d_valid,
   output logic [3:0]        d_icode,
   output logic [3:0]        d_ifun,
   output logic [3:0]        d_ra,
   output logic [3:0]        d_rb,
   output logic [63:0]       d_valc,
   output logic [ADDR_W-1:0] d_valp,
   output logic [2:0]        d_stat,
   output logic [ADDR_W-1:0] pc
);

   localparam int unsigned IDX_W   = $clog2(MEM_BYTES);
   localparam int unsigned MAX_LEN = 10;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {RUN, RET_WAIT, HALTED} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                d_valid_q, d_valid_d;
   logic [3:0]          d_icode_q, d_icode_d, d_ifun_q, d_ifun_d;
   logic [3:0]          d_ra_q, d_ra_d, d_rb_q, d_rb_d;
   logic [63:0]         d_valc_q, d_valc_d;
   logic [ADDR_W-1:0]   d_valp_q, d_valp_d;
   logic [2:0]          d_stat_q, d_stat_d;

   logic [7:0]          mem_q [MEM_BYTES];
   logic [ADDR_W:0]     byte_addr [MAX_LEN];
   logic [MAX_LEN-1:0]  byte_oob;
   logic [7:0]          fbyte [MAX_LEN];

   logic [3:0]          f_icode, f_ifun, f_ra, f_rb, f_len;
   logic [63:0]         f_valc;
   logic [ADDR_W-1:0]   f_valp, f_pred;
   logic [2:0]          f_stat;
   logic                f_adr;

   always_ff @(posedge clock) begin
      if (load_en && ({1'b0, load_addr} < (ADDR_W+1)'(MEM_BYTES)))
         mem_q[load_addr[IDX_W-1:0]] <= load_data;
   end

   // Extra address bit keeps pc+i from wrapping back into range.
   always_comb begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         byte_addr[i] = {1'b0, pc_q} + (ADDR_W+1)'(i);
         byte_oob[i]  = byte_addr[i] >= (ADDR_W+1)'(MEM_BYTES);
         fbyte[i]     = byte_oob[i] ? 8'h00 : mem_q[byte_addr[i][IDX_W-1:0]];
      end
   end

   always_comb begin
      f_icode = fbyte[0][7:4];
      f_ifun  = fbyte[0][3:0];
      f_ra    = 4'hF;
      f_rb    = 4'hF;
      f_valc  = '0;
      f_len   = 4'd1;
      unique case (f_icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin
            f_len = 4'd2;
            f_ra  = fbyte[1][7:4];
            f_rb  = fbyte[1][3:0];
         end
         4'h3, 4'h4, 4'h5: begin
            f_len  = 4'd10;
            f_ra   = fbyte[1][7:4];
            f_rb   = fbyte[1][3:0];
            f_valc = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                      fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
         end
         4'h7, 4'h8: begin
            f_len  = 4'd9;
            f_valc = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                      fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
         end
         default: ;
      endcase
      f_adr  = byte_oob[f_len - 4'd1];
      f_valp = pc_q + ADDR_W'(f_len);
      if (f_adr)                f_stat = STAT_ADR;
      else if (f_icode > 4'hB)  f_stat = STAT_INS;
      else if (f_icode == 4'h0) f_stat = STAT_HLT;
      else                      f_stat = STAT_AOK;
`ifdef FETCH_PREDICT_EN
      f_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? ADDR_W'(f_valc) : f_valp;
`else
      f_pred = f_valp;
`endif
   end

   // Next state: redirect beats stall; faulting instructions leave PC on themselves.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      d_valid_d = d_valid_q;
      d_icode_d = d_icode_q;
      d_ifun_d  = d_ifun_q;
      d_ra_d    = d_ra_q;
      d_rb_d    = d_rb_q;
      d_valc_d  = d_valc_q;
      d_valp_d  = d_valp_q;
      d_stat_d  = d_stat_q;
      if (redirect_valid || (!stall && state_q != RUN)) begin
         d_valid_d = 1'b0;
         d_icode_d = 4'h1;
         d_ifun_d  = 4'h0;
         d_ra_d    = 4'hF;
         d_rb_d    = 4'hF;
         d_valc_d  = '0;
         d_valp_d  = '0;
         d_stat_d  = STAT_AOK;
      end
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = RUN;
      end else if (!stall && state_q == RUN) begin
         d_valid_d = 1'b1;
         d_icode_d = f_icode;
         d_ifun_d  = f_ifun;
         d_ra_d    = f_ra;
         d_rb_d    = f_rb;
         d_valc_d  = f_valc;
         d_valp_d  = f_valp;
         d_stat_d  = f_stat;
         if (f_stat != STAT_AOK) begin
            state_d = HALTED;
         end else begin
            pc_d = f_pred;
            if (f_icode == 4'h9) state_d = RET_WAIT;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         d_valid_q <= 1'b0;
         d_icode_q <= 4'h1;
         d_ifun_q  <= 4'h0;
         d_ra_q    <= 4'hF;
         d_rb_q    <= 4'hF;
         d_valc_q  <= '0;
         d_valp_q  <= '0;
         d_stat_q  <= STAT_AOK;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         d_valid_q <= d_valid_d;
         d_icode_q <= d_icode_d;
         d_ifun_q  <= d_ifun_d;
         d_ra_q    <= d_ra_d;
         d_rb_q    <= d_rb_d;
         d_valc_q  <= d_valc_d;
         d_valp_q  <= d_valp_d;
         d_stat_q  <= d_stat_d;
      end
   end

   assign d_valid = d_valid_q;
   assign d_icode = d_icode_q;
   assign d_ifun  = d_ifun_q;
   assign d_ra    = d_ra_q;
   assign d_rb    = d_rb_q;
   assign d_valc  = d_valc_q;
   assign d_valp  = d_valp_q;
   assign d_stat  = d_stat_q;
   assign pc      = pc_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit; expectations follow FETCH_PREDICT_EN when defined.
module tb_y86_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_en = 1'b0;
   logic [63:0] load_addr = '0;
   logic [7:0]  load_data = '0;
   logic        stall = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        d_valid;
   logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
   logic [63:0] d_valc, d_valp, pc;
   logic [2:0]  d_stat;

   int checks = 0;
   int errors = 0;

   y86_fetch_unit #(.MEM_BYTES(1024), .ADDR_W(64), .RESET_PC(64'h0)) dut (
      .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
      .d_ra(d_ra), .d_rb(d_rb), .d_valc(d_valc), .d_valp(d_valp), .d_stat(d_stat), .pc(pc)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_byte(input logic [63:0] a, input logic [7:0] b);
      stall     = 1'b1;
      load_en   = 1'b1;
      load_addr = a;
      load_data = b;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      #3;
      reset = 1'b0;
   endtask

   task automatic redirect_to(input logic [63:0] a);
      stall = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = a;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      load_byte(64'd0, 8'h60); load_byte(64'd1, 8'h23);
      load_byte(64'd2, 8'h30); load_byte(64'd3, 8'hF4); load_byte(64'd4, 8'h08);
      for (int i = 5; i < 12; i++) load_byte(64'(i), 8'h00);
      load_byte(64'd12, 8'h10); load_byte(64'd13, 8'h00);
      do_reset();
      checks++;
      if (d_valid !== 1'b0 || d_icode !== 4'h1 || d_ra !== 4'hF || d_valp !== 64'd0 || d_stat !== 3'd1 || pc !== 64'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b icode=%h ra=%h valp=%h stat=%0d pc=%h, want 0 1 F 0 1 0", d_valid, d_icode, d_ra, d_valp, d_stat, pc);
      end
   endtask

   task automatic test_sequence();
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h6 || d_ra !== 4'h2 || d_rb !== 4'h3 || d_valp !== 64'd2 || pc !== 64'd2) begin
         errors++;
         $display("FAIL seq_opq: valid=%b icode=%h ra=%h rb=%h valp=%0d pc=%0d, want 1 6 2 3 2 2", d_valid, d_icode, d_ra, d_rb, d_valp, pc);
      end
      tick();
      checks++;
      if (d_icode !== 4'h3 || d_ra !== 4'hF || d_rb !== 4'h4 || d_valc !== 64'd8 || d_valp !== 64'd12 || d_stat !== 3'd1) begin
         errors++;
         $display("FAIL seq_irmovq: icode=%h ra=%h rb=%h valc=%h valp=%0d stat=%0d, want 3 F 4 8 12 1", d_icode, d_ra, d_rb, d_valc, d_valp, d_stat);
      end
      tick();
      checks++;
      if (d_icode !== 4'h1 || d_valp !== 64'd13 || d_ra !== 4'hF || d_valc !== 64'd0 || pc !== 64'd13) begin
         errors++;
         $display("FAIL seq_nop: icode=%h valp=%0d ra=%h valc=%h pc=%0d, want 1 13 F 0 13", d_icode, d_valp, d_ra, d_valc, pc);
      end
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h0 || d_stat !== 3'd2 || pc !== 64'd13) begin
         errors++;
         $display("FAIL seq_halt: valid=%b icode=%h stat=%0d pc=%0d, want 1 0 2 13", d_valid, d_icode, d_stat, pc);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (d_valid !== 1'b0 || d_icode !== 4'h1 || d_stat !== 3'd1 || d_valp !== 64'd0 || pc !== 64'd13) begin
            errors++;
            $display("FAIL seq_halted_bubble: valid=%b icode=%h stat=%0d valp=%0d pc=%0d, want 0 1 1 0 13", d_valid, d_icode, d_stat, d_valp, pc);
         end
      end
   endtask

   task automatic test_jump();
      logic [63:0] exp_pc;
      load_byte(64'd0, 8'h70); load_byte(64'd1, 8'h20);
      for (int i = 2; i < 9; i++) load_byte(64'(i), 8'h00);
      load_byte(64'd9, 8'h00); load_byte(64'h20, 8'h10);
      do_reset();
`ifdef FETCH_PREDICT_EN
      exp_pc = 64'h20;
`else
      exp_pc = 64'd9;
`endif
      tick();
      checks++;
      if (d_icode !== 4'h7 || d_valc !== 64'h20 || d_valp !== 64'd9 || d_ra !== 4'hF || pc !== exp_pc) begin
         errors++;
         $display("FAIL jmp_decode: icode=%h valc=%h valp=%0d ra=%h pc=%h, want 7 20 9 F %h", d_icode, d_valc, d_valp, d_ra, pc, exp_pc);
      end
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_valp !== exp_pc + 64'd1) begin
         errors++;
         $display("FAIL jmp_target: valid=%b valp=%h, want 1 %h", d_valid, d_valp, exp_pc + 64'd1);
      end
   endtask

   task automatic test_ret();
      load_byte(64'h10, 8'h90); load_byte(64'h40, 8'h10);
      redirect_to(64'h10);
      checks++;
      if (d_valid !== 1'b0 || pc !== 64'h10) begin
         errors++;
         $display("FAIL ret_redirect_in: valid=%b pc=%h, want 0 10", d_valid, pc);
      end
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h9 || d_valp !== 64'h11 || pc !== 64'h11) begin
         errors++;
         $display("FAIL ret_latch: valid=%b icode=%h valp=%h pc=%h, want 1 9 11 11", d_valid, d_icode, d_valp, pc);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (d_valid !== 1'b0 || d_icode !== 4'h1 || pc !== 64'h11) begin
            errors++;
            $display("FAIL ret_wait: valid=%b icode=%h pc=%h, want 0 1 11", d_valid, d_icode, pc);
         end
      end
      redirect_to(64'h40);
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h1 || d_valp !== 64'h41) begin
         errors++;
         $display("FAIL ret_resume: valid=%b icode=%h valp=%h, want 1 1 41", d_valid, d_icode, d_valp);
      end
   endtask

   task automatic test_stall();
      load_byte(64'd0, 8'h60); load_byte(64'd1, 8'h23);
      load_byte(64'd2, 8'h10); load_byte(64'd3, 8'h10); load_byte(64'd4, 8'h00);
      do_reset();
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (d_valid !== 1'b1 || d_icode !== 4'h6 || d_valp !== 64'd2 || pc !== 64'd2) begin
            errors++;
            $display("FAIL stall_hold: valid=%b icode=%h valp=%0d pc=%0d, want 1 6 2 2", d_valid, d_icode, d_valp, pc);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (d_icode !== 4'h1 || d_valp !== 64'd3 || pc !== 64'd3) begin
         errors++;
         $display("FAIL stall_release: icode=%h valp=%0d pc=%0d, want 1 3 3", d_icode, d_valp, pc);
      end
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'd0;
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      checks++;
      if (d_valid !== 1'b0 || d_icode !== 4'h1 || pc !== 64'd0) begin
         errors++;
         $display("FAIL stall_vs_redirect: valid=%b icode=%h pc=%0d, want 0 1 0", d_valid, d_icode, pc);
      end
   endtask

   task automatic test_async_reset();
      load_byte(64'h30, 8'h00);
      redirect_to(64'h30);
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_stat !== 3'd2 || pc !== 64'h30) begin
         errors++;
         $display("FAIL areset_pre: valid=%b stat=%0d pc=%h, want 1 2 30", d_valid, d_stat, pc);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (d_valid !== 1'b0 || d_icode !== 4'h1 || d_stat !== 3'd1 || d_rb !== 4'hF || pc !== 64'd0) begin
         errors++;
         $display("FAIL areset_async: valid=%b icode=%h stat=%0d rb=%h pc=%h, want 0 1 1 F 0", d_valid, d_icode, d_stat, d_rb, pc);
      end
      #1;
      reset = 1'b0;
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h6 || pc !== 64'd2) begin
         errors++;
         $display("FAIL areset_resume: valid=%b icode=%h pc=%0d, want 1 6 2", d_valid, d_icode, pc);
      end
   endtask

   task automatic test_status();
      load_byte(64'd1019, 8'h30); load_byte(64'd1020, 8'hF4);
      redirect_to(64'd1019);
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'h3 || d_stat !== 3'd3 || pc !== 64'd1019) begin
         errors++;
         $display("FAIL adr_stat: valid=%b icode=%h stat=%0d pc=%0d, want 1 3 3 1019", d_valid, d_icode, d_stat, pc);
      end
      tick();
      checks++;
      if (d_valid !== 1'b0 || pc !== 64'd1019) begin
         errors++;
         $display("FAIL adr_halted: valid=%b pc=%0d, want 0 1019", d_valid, pc);
      end
      load_byte(64'd0, 8'hC0);
      redirect_to(64'd0);
      tick();
      checks++;
      if (d_valid !== 1'b1 || d_icode !== 4'hC || d_stat !== 3'd4 || pc !== 64'd0) begin
         errors++;
         $display("FAIL ins_stat: valid=%b icode=%h stat=%0d pc=%0d, want 1 C 4 0", d_valid, d_icode, d_stat, pc);
      end
      load_byte(64'd1024, 8'h10);
      redirect_to(64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      checks++;
      if (d_stat !== 3'd3 || pc !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++;
         $display("FAIL adr_wrap: stat=%0d pc=%h, want 3 fffffffffffffffe", d_stat, pc);
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_jump();
      test_ret();
      test_stall();
      test_async_reset();
      test_status();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
